// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory read port, redirect input,
// and the instruction output handshake toward the type decoder.
// master = fetch unit side, slave = memory/decoder/branch side.
interface fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic        fetch_err;

  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc, opcode, fetch_err,
    input  mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc, opcode, fetch_err,
    output mem_rvalid, mem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-entry instruction fetch unit with one outstanding memory read.
// Optional memory-response watchdog enabled by defining FETCH_TIMEOUT_EN;
// without it WAIT/DRAIN wait indefinitely and fetch_err is tied low.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic       clk,
  input logic       rst,
  fetch_unit_if.master bus
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, FULL, ERR} state_t;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          timeout;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, FULL} state_t;
`endif

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] inst_q, inst_pc_q;
  logic [31:0] redirect_target;
  logic        load_inst;

  assign redirect_target = bus.redirect_pc & ~32'h0000_0003;

`ifdef FETCH_TIMEOUT_EN
  assign timeout = (state == WAIT || state == DRAIN) && !bus.mem_rvalid &&
                   (cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state and next-pc selection; redirect always overrides pc
  always_comb begin
    state_next = state;
    pc_next    = pc;
    load_inst  = 1'b0;
    case (state)
      IDLE:  state_next = REQ;
      REQ:   state_next = bus.redirect ? DRAIN : WAIT;
      WAIT: begin
`ifdef FETCH_TIMEOUT_EN
        if (timeout) state_next = ERR;
        else
`endif
        if (bus.redirect) begin
          state_next = bus.mem_rvalid ? REQ : DRAIN;
        end else if (bus.mem_rvalid) begin
          state_next = FULL;
          load_inst  = 1'b1;
          pc_next    = pc + 32'd4;
        end
      end
      DRAIN: begin
`ifdef FETCH_TIMEOUT_EN
        if (timeout) state_next = ERR;
        else
`endif
        if (bus.mem_rvalid) state_next = REQ;
      end
      FULL: begin
        if (bus.redirect || bus.inst_ready) state_next = REQ;
      end
`ifdef FETCH_TIMEOUT_EN
      ERR:   state_next = ERR;
`endif
      default: state_next = IDLE;
    endcase
    if (bus.redirect) pc_next = redirect_target;
  end

  // State, pc and instruction register updates
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (load_inst) begin
        inst_q    <= bus.mem_rdata;
        inst_pc_q <= pc;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Watchdog: restart on entry to WAIT/DRAIN, count cycles without a response
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state_next == WAIT || state_next == DRAIN) && state_next != state) begin
      cnt <= '0;
    end else if ((state == WAIT || state == DRAIN) && !bus.mem_rvalid) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.fetch_err = (state == ERR);
`else
  assign bus.fetch_err = 1'b0;
`endif

  assign bus.mem_req    = (state == REQ);
  assign bus.mem_addr   = (state == REQ) ? pc : '0;
  assign bus.inst_valid = (state == FULL);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.opcode     = inst_q[6:0];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, holding the PC value loaded on reset.
REQ-002 The block SHALL provide parameter TIMEOUT_CYCLES, default 16, setting the memory response watchdog limit in cycles.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 mem_req  out  1  one-cycle instruction-memory read request.
REQ-006 mem_addr  out  32  read address, valid while mem_req=1.
REQ-007 mem_rvalid  in  1  read data valid.
REQ-008 mem_rdata  in  32  read data.
REQ-009 redirect  in  1  branch/jump redirect strobe.
REQ-010 redirect_pc  in  32  redirect target.
REQ-011 inst_valid  out  1  instruction register holds a valid instruction.
REQ-012 inst_ready  in  1  downstream type decoder accepts the instruction.
REQ-013 inst  out  32  fetched instruction.
REQ-014 inst_pc  out  32  address of inst.
REQ-015 opcode  out  7  inst[6:0], driven combinationally for the type decoder.
REQ-016 fetch_err  out  1  sticky memory-timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, DRAIN, FULL and ERR.
REQ-018 IDLE SHALL go to REQ on the next cycle and ignore mem_rvalid.
REQ-019 REQ SHALL drive mem_req=1 and mem_addr=pc for exactly one cycle, then go to WAIT.
REQ-020 In WAIT, mem_rvalid=1 SHALL latch inst=mem_rdata and inst_pc=pc, set pc=pc+4, and go to FULL.
REQ-021 inst_valid SHALL be 1 only in FULL.
REQ-022 In FULL, inst_ready=1 SHALL go to REQ on the next cycle.
REQ-023 In FULL, inst, inst_pc and opcode SHALL stay stable while inst_ready=0.
REQ-024 Only one memory request SHALL be outstanding at any time.
REQ-025 Minimum throughput SHALL be one instruction per 3 cycles with a 1-cycle memory.
REQ-026 When redirect=1, pc SHALL load {redirect_pc[31:2],2'b00}, so redirect targets are force-aligned.
REQ-027 Redirect in FULL SHALL discard the instruction, even if inst_ready=1, and go to REQ.
REQ-028 Redirect in REQ SHALL go to DRAIN.
REQ-029 Redirect in WAIT with mem_rvalid=0 SHALL go to DRAIN.
REQ-030 Redirect in WAIT with mem_rvalid=1 SHALL discard the data and go to REQ.
REQ-031 DRAIN SHALL discard the next mem_rvalid response, then go to REQ; a further redirect in DRAIN SHALL only update pc.
REQ-032 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).

Reset
REQ-033 When rst=1, outputs SHALL reset to mem_req=0, mem_addr=0, inst_valid=0, inst=0, inst_pc=0, opcode=0, fetch_err=0.
REQ-034 When rst=1, pc SHALL load RESET_PC and the state SHALL become IDLE.
REQ-035 rst SHALL take priority over redirect and mem_rvalid.
REQ-036 A response arriving after a mid-transaction reset SHALL be ignored.

Configuration
REQ-037 With macro FETCH_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT or DRAIN and increment each cycle without mem_rvalid.
REQ-038 With FETCH_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL move the FSM to ERR, which SHALL hold fetch_err=1 and issue no requests until rst.
REQ-039 Without FETCH_TIMEOUT_EN, there SHALL be no counter and no ERR state, fetch_err SHALL be tied to 0, and WAIT/DRAIN SHALL wait indefinitely.

Verification
REQ-040 Release rst, mem responds 1 cycle after mem_req with 32'h0000_0013, inst_ready=1 -> mem_addr sequence 0,4,8; inst=32'h13, opcode=7'h13, inst_pc=0.
REQ-041 Hold inst_ready=0 for 5 cycles in FULL -> inst/inst_pc stable, no mem_req; one mem_req (addr 4) after inst_ready=1.
REQ-042 Redirect to 32'h0000_0102 during WAIT, response arrives 2 cycles later -> response dropped, next mem_addr=32'h0000_0100, no inst_valid for the dropped data.
REQ-043 RESET_PC=32'hFFFF_FFFC, one fetch accepted -> next mem_addr=32'h0000_0000.
REQ-044 With FETCH_TIMEOUT_EN, no mem_rvalid for 16 cycles -> fetch_err=1, mem_req stays 0; rst clears fetch_err and fetching restarts at RESET_PC.
